// File: rtl/coco_kbd_pkg.sv
// Shared matrix geometry, key position type and the PS/2 set-2 to CoCo matrix decode table.
package coco_kbd_pkg;

    localparam int KROWS = 7;
    localparam int KCOLS = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } kbd_pos_t;

    // Both physical shift keys land on r6c7; positions are packed {row, col}.
    localparam logic [5:0] SHIFT_POS = 6'o67;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    function automatic kbd_pos_t at(input int row, input int col);
        kbd_pos_t p;
        p.valid = 1'b1;
        p.row   = 3'(row);
        p.col   = 3'(col);
        return p;
    endfunction

    function automatic kbd_pos_t ps2_to_coco(input logic ext, input logic [7:0] code);
        kbd_pos_t p;
        p = '0;
        if (ext) begin
            case (code)
                8'h75:   p = at(3, 3);
                8'h72:   p = at(3, 4);
                8'h6B:   p = at(3, 5);
                8'h74:   p = at(3, 6);
                8'h6C:   p = at(6, 1);
                default: p = '0;
            endcase
        end else begin
            case (code)
                8'h54:   p = at(0, 0);
                8'h1C:   p = at(0, 1);
                8'h32:   p = at(0, 2);
                8'h21:   p = at(0, 3);
                8'h23:   p = at(0, 4);
                8'h24:   p = at(0, 5);
                8'h2B:   p = at(0, 6);
                8'h34:   p = at(0, 7);
                8'h33:   p = at(1, 0);
                8'h43:   p = at(1, 1);
                8'h3B:   p = at(1, 2);
                8'h42:   p = at(1, 3);
                8'h4B:   p = at(1, 4);
                8'h3A:   p = at(1, 5);
                8'h31:   p = at(1, 6);
                8'h44:   p = at(1, 7);
                8'h4D:   p = at(2, 0);
                8'h15:   p = at(2, 1);
                8'h2D:   p = at(2, 2);
                8'h1B:   p = at(2, 3);
                8'h2C:   p = at(2, 4);
                8'h3C:   p = at(2, 5);
                8'h2A:   p = at(2, 6);
                8'h1D:   p = at(2, 7);
                8'h22:   p = at(3, 0);
                8'h35:   p = at(3, 1);
                8'h1A:   p = at(3, 2);
                8'h66:   p = at(3, 5);
                8'h29:   p = at(3, 7);
                8'h45:   p = at(4, 0);
                8'h16:   p = at(4, 1);
                8'h1E:   p = at(4, 2);
                8'h26:   p = at(4, 3);
                8'h25:   p = at(4, 4);
                8'h2E:   p = at(4, 5);
                8'h36:   p = at(4, 6);
                8'h3D:   p = at(4, 7);
                8'h3E:   p = at(5, 0);
                8'h46:   p = at(5, 1);
                8'h52:   p = at(5, 2);
                8'h4C:   p = at(5, 3);
                8'h41:   p = at(5, 4);
                8'h4E:   p = at(5, 5);
                8'h49:   p = at(5, 6);
                8'h4A:   p = at(5, 7);
                8'h5A:   p = at(6, 0);
                8'h76:   p = at(6, 2);
                8'h12:   p = at(6, 7);
                8'h59:   p = at(6, 7);
                default: p = '0;
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/coco_keymatrix.sv
// PS/2 event stream to CoCo keyboard matrix, with a minimum-hold timer so short
// make/break pairs stay visible to a polling CPU, and a registered column-strobe read port.
module coco_keymatrix
    import coco_kbd_pkg::*;
#(
    parameter int HOLD_MIN = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  col_n,
    output logic [6:0]  row_n,
    output logic        any_key,
    output logic        break_key
);

    localparam int CW = (HOLD_MIN > 0) ? $clog2(HOLD_MIN + 1) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_MIN);
    localparam logic [CW-1:0] HOLD_ONE  = CW'(1);

    logic                        toggle_q;
    logic                        armed;
    logic                        event_v;
    logic                        is_make;
    kbd_pos_t                    pos;
    logic [5:0]                  key;

    logic [KROWS-1:0][KCOLS-1:0] m, m_next;
    logic [5:0]                  pend_bit, pend_bit_next;
    logic                        pend_v, pend_v_next;
    logic [5:0]                  hold_bit, hold_bit_next;
    logic [CW-1:0]               hold_cnt, hold_cnt_next;
    logic                        lsh, lsh_next;
    logic                        rsh, rsh_next;
    logic [KROWS-1:0]            row_hit;

    // The first clock after reset only primes the toggle copy, so a high toggle bit is not an event.
    assign event_v = armed && (ps2_key[10] != toggle_q);
    assign is_make = ps2_key[9];
    assign pos     = ps2_to_coco(ps2_key[8], ps2_key[7:0]);
    assign key     = {pos.row, pos.col};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle_q <= 1'b0;
            armed    <= 1'b0;
        end else begin
            toggle_q <= ps2_key[10];
            armed    <= 1'b1;
        end
    end

    // Timer expiry is applied before the incoming event so the event sees the post-expiry state.
    always_comb begin
        m_next        = m;
        pend_bit_next = pend_bit;
        pend_v_next   = pend_v;
        hold_bit_next = hold_bit;
        hold_cnt_next = hold_cnt;
        lsh_next      = lsh;
        rsh_next      = rsh;

        if (hold_cnt != '0) begin
            hold_cnt_next = hold_cnt - HOLD_ONE;
        end
        if (pend_v && (hold_cnt == HOLD_ONE)) begin
            pend_v_next = 1'b0;
            if (!((pend_bit == SHIFT_POS) && (lsh || rsh))) begin
                m_next[pend_bit[5:3]][pend_bit[2:0]] = 1'b0;
            end
        end

        if (event_v && pos.valid) begin
            if (is_make) begin
                if (pend_v_next && (pend_bit == key)) begin
                    pend_v_next = 1'b0;
                end else if (pend_v_next) begin
                    pend_v_next = 1'b0;
                    if (!((pend_bit == SHIFT_POS) && (lsh || rsh))) begin
                        m_next[pend_bit[5:3]][pend_bit[2:0]] = 1'b0;
                    end
                end
                m_next[pos.row][pos.col] = 1'b1;
                if (ps2_key[7:0] == SC_LSHIFT) lsh_next = 1'b1;
                if (ps2_key[7:0] == SC_RSHIFT) rsh_next = 1'b1;
                hold_cnt_next = HOLD_LOAD;
                hold_bit_next = key;
            end else begin
                if (ps2_key[7:0] == SC_LSHIFT) lsh_next = 1'b0;
                if (ps2_key[7:0] == SC_RSHIFT) rsh_next = 1'b0;
                if ((key == hold_bit) && (hold_cnt_next != '0)) begin
                    pend_bit_next = key;
                    pend_v_next   = 1'b1;
                end else if (!((key == SHIFT_POS) && (lsh_next || rsh_next))) begin
                    m_next[pos.row][pos.col] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m        <= '0;
            pend_bit <= '0;
            pend_v   <= 1'b0;
            hold_bit <= '0;
            hold_cnt <= '0;
            lsh      <= 1'b0;
            rsh      <= 1'b0;
        end else begin
            m        <= m_next;
            pend_bit <= pend_bit_next;
            pend_v   <= pend_v_next;
            hold_bit <= hold_bit_next;
            hold_cnt <= hold_cnt_next;
            lsh      <= lsh_next;
            rsh      <= rsh_next;
        end
    end

    always_comb begin
        row_hit = '0;
        for (int r = 0; r < KROWS; r++) begin
            row_hit[r] = |(~col_n & m[r]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_n     <= 7'h7F;
            any_key   <= 1'b0;
            break_key <= 1'b0;
        end else begin
            row_n     <= ~row_hit;
            any_key   <= |m;
            break_key <= m[6][2];
        end
    end

endmodule
